// File: rtl/stream_combiner_if.sv
// Stream bundle for stream_combiner: two payload inputs (AM0/AM1), one joined output (BM).
// slave is the combiner side; master is the side that drives the inputs and sinks the output.
interface stream_combiner_if #(
  parameter int WIDTH0 = 32,
  parameter int WIDTH1 = 32
);
  logic                     iValid_AM0;
  logic                     oReady_AM0;
  logic [WIDTH0-1:0]        iData_AM0;
  logic                     iValid_AM1;
  logic                     oReady_AM1;
  logic [WIDTH1-1:0]        iData_AM1;
  logic                     oValid_BM;
  logic                     iReady_BM;
  logic [WIDTH0+WIDTH1-1:0] oData_BM;

  modport slave (
    input  iValid_AM0, iData_AM0, iValid_AM1, iData_AM1, iReady_BM,
    output oReady_AM0, oReady_AM1, oValid_BM, oData_BM
  );

  modport master (
    output iValid_AM0, iData_AM0, iValid_AM1, iData_AM1, iReady_BM,
    input  oReady_AM0, oReady_AM1, oValid_BM, oData_BM
  );
endinterface

// File: rtl/stream_combiner_slot.sv
// One-word holding slot for a combiner input.
// Ready depends only on the slot flag (and reset), never on the output side.
// o_av/o_src present either the held word or the live input word so the join can bypass the slot.
module stream_combiner_slot #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_fire,
  output logic             o_ready,
  output logic             o_av,
  output logic [WIDTH-1:0] o_src
);
  logic             r_hv;
  logic [WIDTH-1:0] r_data;
  logic             w_accept;

  assign o_ready  = i_rst_n & ~r_hv;
  assign w_accept = i_valid & o_ready;
  assign o_av     = r_hv | i_valid;
  assign o_src    = r_hv ? r_data : i_data;

  // Fire empties the slot (or bypasses it); an accept without fire parks the word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hv   <= 1'b0;
      r_data <= '0;
    end else if (i_fire) begin
      r_hv <= 1'b0;
    end else if (w_accept) begin
      r_hv   <= 1'b1;
      r_data <= i_data;
    end
  end
endmodule

// File: rtl/stream_combiner.sv
// Two-input stream join: one word from each input becomes one {d0, d1} output word.
// BURST="yes" uses a main+skid output pair for one word per cycle;
// BURST="no" uses a single output register and emits at most every other cycle.
module stream_combiner #(
  parameter int    WIDTH0 = 32,
  parameter int    WIDTH1 = 32,
  parameter string BURST  = "yes"
) (
  input  logic              iCLK,
  input  logic              iRST,
  stream_combiner_if.slave  bus
);
  localparam int WO = WIDTH0 + WIDTH1;

  logic              w_av0, w_av1;
  logic              w_ready0, w_ready1;
  logic [WIDTH0-1:0] w_src0;
  logic [WIDTH1-1:0] w_src1;
  logic [WO-1:0]     w_word;
  logic              w_cap;
  logic              w_fire;

  logic              r_main_v;
  logic [WO-1:0]     r_main;

  stream_combiner_slot #(.WIDTH(WIDTH0)) u_slot0 (
    .i_clk   (iCLK),
    .i_rst_n (iRST),
    .i_valid (bus.iValid_AM0),
    .i_data  (bus.iData_AM0),
    .i_fire  (w_fire),
    .o_ready (w_ready0),
    .o_av    (w_av0),
    .o_src   (w_src0)
  );

  stream_combiner_slot #(.WIDTH(WIDTH1)) u_slot1 (
    .i_clk   (iCLK),
    .i_rst_n (iRST),
    .i_valid (bus.iValid_AM1),
    .i_data  (bus.iData_AM1),
    .i_fire  (w_fire),
    .o_ready (w_ready1),
    .o_av    (w_av1),
    .o_src   (w_src1)
  );

  assign w_word         = {w_src0, w_src1};
  assign w_fire         = w_av0 & w_av1 & w_cap;
  assign bus.oReady_AM0 = w_ready0;
  assign bus.oReady_AM1 = w_ready1;
  assign bus.oValid_BM  = r_main_v;
  assign bus.oData_BM   = r_main;

  generate
    if (BURST == "yes") begin : g_burst
      logic          r_skid_v;
      logic [WO-1:0] r_skid;
      logic          w_drain;

      assign w_drain = r_main_v & bus.iReady_BM;
      assign w_cap   = ~r_skid_v;

      // Main+skid pair: fire lands in main when it is free or leaving, otherwise in skid;
      // a draining main refills from skid. Fire is blocked while skid is occupied.
      always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
          r_main_v <= 1'b0;
          r_main   <= '0;
          r_skid_v <= 1'b0;
          r_skid   <= '0;
        end else if (w_fire) begin
          if (!r_main_v || w_drain) begin
            r_main   <= w_word;
            r_main_v <= 1'b1;
          end else begin
            r_skid   <= w_word;
            r_skid_v <= 1'b1;
          end
        end else if (w_drain) begin
          if (r_skid_v) begin
            r_main   <= r_skid;
            r_skid_v <= 1'b0;
          end else begin
            r_main_v <= 1'b0;
          end
        end
      end
    end else begin : g_single
      assign w_cap = ~r_main_v;

      // Single register: only loads when empty, so load and drain alternate.
      always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
          r_main_v <= 1'b0;
          r_main   <= '0;
        end else if (w_fire) begin
          r_main   <= w_word;
          r_main_v <= 1'b1;
        end else if (r_main_v && bus.iReady_BM) begin
          r_main_v <= 1'b0;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_stream_combiner.sv
// Bench for stream_combiner: scoreboard on a BURST="yes" 32/32 instance, plus a
// BURST="no" instance for throughput and an 8/24 instance for field packing.
module tb_stream_combiner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_combiner_if #(.WIDTH0(32), .WIDTH1(32)) b();
  stream_combiner_if #(.WIDTH0(32), .WIDTH1(32)) h();
  stream_combiner_if #(.WIDTH0(8),  .WIDTH1(24)) n();

  stream_combiner #(.WIDTH0(32), .WIDTH1(32), .BURST("yes")) u_burst (.iCLK(clk), .iRST(rst_n), .bus(b));
  stream_combiner #(.WIDTH0(32), .WIDTH1(32), .BURST("no"))  u_half  (.iCLK(clk), .iRST(rst_n), .bus(h));
  stream_combiner #(.WIDTH0(8),  .WIDTH1(24), .BURST("yes")) u_narrow(.iCLK(clk), .iRST(rst_n), .bus(n));

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  // Reference model: each input is a FIFO of accepted words; the join pairs heads in order.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [63:0] exp_q[$];

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (b.iValid_AM0 && b.oReady_AM0) q0.push_back(b.iData_AM0);
      if (b.iValid_AM1 && b.oReady_AM1) q1.push_back(b.iData_AM1);
      while (q0.size() > 0 && q1.size() > 0) exp_q.push_back({q0.pop_front(), q1.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (rst_n && b.oValid_BM && b.iReady_BM) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_unexpected: got=%h want=nothing", b.oData_BM);
      end else begin
        check("out_data", b.oData_BM, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_b();
    b.iValid_AM0 = 1'b0;
    b.iValid_AM1 = 1'b0;
    b.iReady_BM  = 1'b1;
  endtask

  task automatic drain_b(string name);
    idle_b();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      next_cycle();
    end
    repeat (3) next_cycle();
    check(name, exp_q.size(), 0);
  endtask

  task automatic run_random(int ncyc);
    logic hs0, hs1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      hs0 = b.iValid_AM0 && b.oReady_AM0;
      hs1 = b.iValid_AM1 && b.oReady_AM1;
      next_cycle();
      if (hs0 || !b.iValid_AM0) begin
        b.iValid_AM0 = ($urandom_range(0, 99) < 70);
        b.iData_AM0  = $urandom;
      end
      if (hs1 || !b.iValid_AM1) begin
        b.iValid_AM1 = ($urandom_range(0, 99) < 55);
        b.iData_AM1  = $urandom;
      end
      b.iReady_BM = ($urandom_range(0, 99) < 65);
    end
  endtask

  initial begin
    int base, bad, rbad, k0, k1, nout;
    logic hs0, hs1, prev;
    logic [31:0] e0, e1;

    b.iValid_AM0 = 0; b.iValid_AM1 = 0; b.iData_AM0 = '0; b.iData_AM1 = '0; b.iReady_BM = 0;
    h.iValid_AM0 = 0; h.iValid_AM1 = 0; h.iData_AM0 = '0; h.iData_AM1 = '0; h.iReady_BM = 0;
    n.iValid_AM0 = 0; n.iValid_AM1 = 0; n.iData_AM0 = '0; n.iData_AM1 = '0; n.iReady_BM = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ovalid", b.oValid_BM, 0);
    check("rst_odata",  b.oData_BM, 0);
    check("rst_rdy0",   b.oReady_AM0, 0);
    check("rst_rdy1",   b.oReady_AM1, 0);
    @(posedge clk); #2; rst_n = 1'b1;
    idle_b();
    @(negedge clk);
    check("rel_rdy", {b.oReady_AM0, b.oReady_AM1}, 2'b11);

    // Field packing, 8/24 split
    next_cycle();
    n.iData_AM0 = 8'hC3; n.iData_AM1 = 24'h5A5A5A;
    n.iValid_AM0 = 1; n.iValid_AM1 = 1; n.iReady_BM = 1;
    next_cycle();
    n.iValid_AM0 = 0; n.iValid_AM1 = 0;
    @(negedge clk);
    check("narrow_valid", n.oValid_BM, 1);
    check("narrow_data",  n.oData_BM, 32'hC35A5A5A);

    // Half-throughput mode: 100 cycles of always-valid input carry 50 words
    next_cycle();
    h.iReady_BM = 1; h.iValid_AM0 = 1; h.iValid_AM1 = 1;
    h.iData_AM0 = 32'h1; h.iData_AM1 = 32'h1000_0000;
    k0 = 0; k1 = 0; nout = 0; bad = 0; prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      hs0 = h.iValid_AM0 && h.oReady_AM0;
      hs1 = h.iValid_AM1 && h.oReady_AM1;
      if (i > 0 && h.oValid_BM == prev) bad++;
      prev = h.oValid_BM;
      if (h.oValid_BM) begin
        e0 = 32'(1 + nout);
        e1 = 32'(32'h1000_0000 + nout);
        check("half_data", h.oData_BM, {e0, e1});
        nout++;
      end
      next_cycle();
      if (hs0) begin k0++; h.iData_AM0 = 32'(1 + k0); end
      if (hs1) begin k1++; h.iData_AM1 = 32'(32'h1000_0000 + k1); end
    end
    check("half_count",  nout, 50);
    check("half_toggle", bad, 0);
    h.iValid_AM0 = 0; h.iValid_AM1 = 0;

    // Full throughput: 100 words back-to-back
    idle_b();
    repeat (2) next_cycle();
    base = n_out; bad = 0; rbad = 0;
    b.iData_AM0 = 32'h1; b.iData_AM1 = 32'h1000_0000;
    b.iValid_AM0 = 1; b.iValid_AM1 = 1;
    for (int i = 0; i < 100; i++) begin
      next_cycle();
      if (i < 99) begin
        b.iData_AM0 = 32'(1 + i + 1);
        b.iData_AM1 = 32'(32'h1000_0000 + i + 1);
      end else begin
        b.iValid_AM0 = 0; b.iValid_AM1 = 0;
      end
      @(negedge clk);
      if (i == 0) check("burst_first_valid", b.oValid_BM, 1);
      if (!b.oValid_BM) bad++;
      if (i < 99 && !(b.oReady_AM0 && b.oReady_AM1)) rbad++;
    end
    next_cycle();
    next_cycle();
    check("burst_bubbles", bad, 0);
    check("burst_ready",   rbad, 0);
    check("burst_count",   n_out - base, 100);

    // Skewed producers: AM0 at cycle 0, AM1 at cycle 3
    idle_b();
    repeat (3) next_cycle();
    b.iData_AM0 = 32'hA; b.iValid_AM0 = 1;
    @(negedge clk);
    check("skew_rdy0_c0", b.oReady_AM0, 1);
    next_cycle();
    b.iValid_AM0 = 0;
    bad = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin b.iData_AM1 = 32'hB; b.iValid_AM1 = 1; end
      @(negedge clk);
      if (b.oReady_AM0 !== 1'b0 || b.oValid_BM !== 1'b0) bad++;
      if (c == 3) check("skew_rdy1_c3", b.oReady_AM1, 1);
      next_cycle();
    end
    b.iValid_AM1 = 0;
    check("skew_hold", bad, 0);
    @(negedge clk);
    check("skew_out_valid", b.oValid_BM, 1);
    check("skew_out_data",  b.oData_BM, 64'h0000000A_0000000B);
    check("skew_rdy0_c4",   b.oReady_AM0, 1);
    next_cycle();

    // Full condition: output stalled for 10 cycles
    idle_b();
    repeat (2) next_cycle();
    b.iReady_BM = 0; b.iValid_AM0 = 1; b.iValid_AM1 = 1;
    b.iData_AM0 = 32'h4000_0000; b.iData_AM1 = 32'h5000_0000;
    k0 = 0; k1 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      hs0 = b.iValid_AM0 && b.oReady_AM0;
      hs1 = b.iValid_AM1 && b.oReady_AM1;
      next_cycle();
      if (hs0) begin k0++; b.iData_AM0 = 32'(32'h4000_0000 + k0); end
      if (hs1) begin k1++; b.iData_AM1 = 32'(32'h5000_0000 + k1); end
    end
    check("full_hs0", k0, 3);
    check("full_hs1", k1, 3);
    @(negedge clk);
    check("full_rdy", {b.oReady_AM0, b.oReady_AM1}, 2'b00);
    next_cycle();
    b.iValid_AM0 = 0; b.iValid_AM1 = 0; b.iReady_BM = 1;
    base = n_out; bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (!b.oValid_BM) bad++;
      next_cycle();
    end
    @(negedge clk);
    check("full_release_end", b.oValid_BM, 0);
    next_cycle();
    check("full_release_gap", bad, 0);
    check("full_release_cnt", n_out - base, 3);

    // Randomized traffic against the scoreboard
    run_random(1500);
    drain_b("random_drain");

    // Reset in the middle of a stalled burst
    b.iReady_BM = 0; b.iValid_AM0 = 1; b.iValid_AM1 = 1;
    b.iData_AM0 = 32'h7700_0000; b.iData_AM1 = 32'h8800_0000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      hs0 = b.iValid_AM0 && b.oReady_AM0;
      hs1 = b.iValid_AM1 && b.oReady_AM1;
      next_cycle();
      if (hs0) b.iData_AM0 = b.iData_AM0 + 1;
      if (hs1) b.iData_AM1 = b.iData_AM1 + 1;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ovalid", b.oValid_BM, 0);
    check("midrst_odata",  b.oData_BM, 0);
    check("midrst_rdy0",   b.oReady_AM0, 0);
    check("midrst_rdy1",   b.oReady_AM1, 0);
    q0.delete(); q1.delete(); exp_q.delete();
    idle_b();
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    @(negedge clk);
    check("midrst_rel_rdy", {b.oReady_AM0, b.oReady_AM1}, 2'b11);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (b.oValid_BM) bad++;
    end
    check("midrst_no_stale", bad, 0);

    run_random(300);
    drain_b("final_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
